// File: rtl/ctl_mpy_seq.sv
// ctl_mpy_seq: multiply/divide step sequencer driving EBOX AR/ARX/MQ controls
// through setup, N shift/add steps, a sign fixup and a completion pulse.
module ctl_mpy_seq #(
    parameter int STEPW = 6
) (
    input  logic             eboxClk,
    input  logic             eboxResetN,
    input  logic             mpyStart,
    input  logic             mpyDivide,
    input  logic [STEPW-1:0] mpySteps,
    input  logic             mpyAbort,
    input  logic             AD_00,
    output logic             CTL_AR00to08load,
    output logic             CTL_AR09to17load,
    output logic             CTL_ARRload,
    output logic             CTL_AR00to11clr,
    output logic             CTL_AR12to17clr,
    output logic             CTL_ARRclr,
    output logic [2:0]       CTL_ARL_SEL,
    output logic [2:0]       CTL_ARR_SEL,
    output logic [2:0]       CTL_ARXL_SEL,
    output logic [2:0]       CTL_ARXR_SEL,
    output logic             CTL_ARX_LOAD,
    output logic [1:0]       CTL_MQ_SEL,
    output logic [1:0]       CTL_MQM_SEL,
    output logic             CTL_MQM_EN,
    output logic             mpyBusy,
    output logic             mpyDone,
    output logic [STEPW-1:0] mpyCount,
    output logic             mpyQbit
);
    typedef enum logic [2:0] {IDLE, SETUP, LOOP, FIX, DONE} state_t;
    state_t state, state_nx;
    logic div;
    always_ff @(posedge eboxClk) begin
        if (!eboxResetN) begin
            state    <= IDLE;
            div      <= 1'b0;
            mpyCount <= '0;
            mpyQbit  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mpyStart) begin
                div      <= mpyDivide;
                mpyCount <= mpySteps;
            end else if (mpyAbort && state != IDLE) begin
                mpyCount <= '0;
            end else if (state == LOOP && mpyCount != '0) begin
                mpyCount <= mpyCount - 1'b1;
            end
            if (state == LOOP && div)
                mpyQbit <= ~AD_00;
        end
    end
    // Moore decode: every control is a function of state and the latched op only.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = mpyStart ? SETUP : IDLE;
            SETUP:   state_nx = (mpyCount != '0) ? LOOP : FIX;
            LOOP:    state_nx = (mpyCount == STEPW'(1)) ? FIX : LOOP;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (mpyAbort && state != IDLE)
            state_nx = IDLE;
        CTL_AR00to08load = state == LOOP || state == FIX;
        CTL_AR09to17load = CTL_AR00to08load;
        CTL_ARRload      = CTL_AR00to08load;
        CTL_AR00to11clr  = state == SETUP;
        CTL_AR12to17clr  = CTL_AR00to11clr;
        CTL_ARRclr       = CTL_AR00to11clr;
        CTL_ARL_SEL      = state == LOOP ? (div ? 3'd2 : 3'd3) : state == FIX ? 3'd1 : 3'd0;
        CTL_ARR_SEL      = CTL_ARL_SEL;
        CTL_ARXL_SEL     = state == LOOP ? (div ? 3'd2 : 3'd3) : 3'd0;
        CTL_ARXR_SEL     = CTL_ARXL_SEL;
        CTL_ARX_LOAD     = state == SETUP || state == LOOP;
        CTL_MQ_SEL       = state == SETUP ? 2'd2 : state == LOOP ? (div ? 2'd3 : 2'd1) : 2'd0;
        CTL_MQM_SEL      = state == LOOP ? (div ? 2'd1 : 2'd2) : 2'd0;
        CTL_MQM_EN       = state == LOOP;
        mpyBusy          = state != IDLE;
        mpyDone          = state == DONE;
    end
endmodule

// File: tb/tb_ctl_mpy_seq.sv
// tb_ctl_mpy_seq: directed and randomized check of ctl_mpy_seq against a cycle-offset model.
module tb_ctl_mpy_seq;
    localparam int STEPW = 6;
    logic eboxClk = 1'b0, eboxResetN = 1'b0, mpyStart = 1'b0, mpyDivide = 1'b0;
    logic mpyAbort = 1'b0, AD_00 = 1'b0;
    logic [STEPW-1:0] mpySteps = '0;
    logic CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload;
    logic CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr;
    logic [2:0] CTL_ARL_SEL, CTL_ARR_SEL, CTL_ARXL_SEL, CTL_ARXR_SEL;
    logic CTL_ARX_LOAD, CTL_MQM_EN, mpyBusy, mpyDone, mpyQbit;
    logic [1:0] CTL_MQ_SEL, CTL_MQM_SEL;
    logic [STEPW-1:0] mpyCount;

    ctl_mpy_seq #(.STEPW(STEPW)) dut (
        .eboxClk(eboxClk), .eboxResetN(eboxResetN), .mpyStart(mpyStart),
        .mpyDivide(mpyDivide), .mpySteps(mpySteps), .mpyAbort(mpyAbort), .AD_00(AD_00),
        .CTL_AR00to08load(CTL_AR00to08load), .CTL_AR09to17load(CTL_AR09to17load),
        .CTL_ARRload(CTL_ARRload), .CTL_AR00to11clr(CTL_AR00to11clr),
        .CTL_AR12to17clr(CTL_AR12to17clr), .CTL_ARRclr(CTL_ARRclr),
        .CTL_ARL_SEL(CTL_ARL_SEL), .CTL_ARR_SEL(CTL_ARR_SEL),
        .CTL_ARXL_SEL(CTL_ARXL_SEL), .CTL_ARXR_SEL(CTL_ARXR_SEL),
        .CTL_ARX_LOAD(CTL_ARX_LOAD), .CTL_MQ_SEL(CTL_MQ_SEL), .CTL_MQM_SEL(CTL_MQM_SEL),
        .CTL_MQM_EN(CTL_MQM_EN), .mpyBusy(mpyBusy), .mpyDone(mpyDone),
        .mpyCount(mpyCount), .mpyQbit(mpyQbit)
    );

    always #5 eboxClk = ~eboxClk;

    int checks = 0, errors = 0;
    // Model: an operation is just "cycles since the start edge" plus its N and kind.
    bit m_busy = 1'b0, m_div = 1'b0, m_q = 1'b0;
    int m_t = 0, m_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int phase();
        if (!m_busy) return 0;
        if (m_t == 1) return 1;
        if (m_t <= m_n + 1) return 2;
        if (m_t == m_n + 2) return 3;
        return 4;
    endfunction

    function automatic logic [25:0] exp_ctl(input int p, input bit dv);
        logic [2:0] s;
        s = dv ? 3'd2 : 3'd3;
        case (p)
            1: return {3'b000, 3'b111, 12'd0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0};
            2: return {3'b111, 3'b000, s, s, s, s, 1'b1, dv ? 2'd3 : 2'd1, dv ? 2'd1 : 2'd2, 1'b1, 1'b1, 1'b0};
            3: return {3'b111, 3'b000, 3'd1, 3'd1, 6'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
            4: return 26'b11;
            default: return 26'd0;
        endcase
    endfunction

    task automatic tick();
        int p, cnt;
        @(posedge eboxClk);
        if (!eboxResetN) begin
            m_busy = 1'b0;
            m_q = 1'b0;
        end else if (m_busy) begin
            if (phase() == 2 && m_div) m_q = ~AD_00;
            if (mpyAbort) m_busy = 1'b0;
            else begin
                m_t++;
                if (m_t == m_n + 4) m_busy = 1'b0;
            end
        end else if (mpyStart) begin
            m_busy = 1'b1;
            m_t = 1;
            m_n = int'(mpySteps);
            m_div = mpyDivide;
        end
        #1;
        p = phase();
        cnt = p == 1 ? m_n : p == 2 ? m_n - (m_t - 2) : 0;
        check("ctl", 32'({CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload, CTL_AR00to11clr,
                          CTL_AR12to17clr, CTL_ARRclr, CTL_ARL_SEL, CTL_ARR_SEL, CTL_ARXL_SEL,
                          CTL_ARXR_SEL, CTL_ARX_LOAD, CTL_MQ_SEL, CTL_MQM_SEL, CTL_MQM_EN,
                          mpyBusy, mpyDone}), 32'(exp_ctl(p, m_div)));
        check("count", 32'(mpyCount), 32'(cnt));
        check("qbit", 32'(mpyQbit), 32'(m_q));
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic go(input bit dv, input int n);
        mpyStart = 1'b1;
        mpyDivide = dv;
        mpySteps = STEPW'(n);
        tick();
        mpyStart = 1'b0;
    endtask

    initial begin
        mpyStart = 1'b1;
        run(2);
        eboxResetN = 1'b1;
        mpyStart = 1'b0;
        run(3);
        go(1'b0, 4);
        run(8);
        go(1'b1, 3);
        tick();
        AD_00 = 1'b0; tick();
        AD_00 = 1'b1; tick();
        AD_00 = 1'b0; tick();
        run(3);
        go(1'b0, 0);
        run(4);
        go(1'b1, 5);
        run(2);
        mpyAbort = 1'b1; tick();
        mpyAbort = 1'b0;
        run(2);
        go(1'b1, 5);
        run(10);
        go(1'b0, 2);
        tick();
        mpyStart = 1'b1; tick();
        mpyStart = 1'b0; run(2);
        mpyStart = 1'b1; tick();
        mpyStart = 1'b0; run(3);
        mpyAbort = 1'b1; run(2);
        mpyAbort = 1'b0;
        eboxResetN = 1'b0; go(1'b1, 7);
        eboxResetN = 1'b1; run(2);
        for (int i = 0; i < 4000; i++) begin
            eboxResetN = $urandom_range(0, 299) != 0;
            mpyStart = $urandom_range(0, 3) == 0;
            mpyAbort = $urandom_range(0, 39) == 0;
            mpyDivide = 1'($urandom_range(0, 1));
            AD_00 = 1'($urandom_range(0, 1));
            mpySteps = $urandom_range(0, 7) == 0 ? STEPW'($urandom_range(0, 63)) : STEPW'($urandom_range(0, 6));
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctl_mpy_seq.md
Name: ctl_mpy_seq

Overview:
- Multiply/divide step sequencer for the EBOX AR/ARX/MQ datapath.
- On a start request it drives the CTL AR load/clear strobes, the AR/ARX/MQ mux selects and the MQM controls through setup, N shift/add steps, a sign fixup and a completion pulse.
- It is the sole driver of these controls while busy. Outside busy its outputs are idle and are ORed externally with the microcode-decoded CTL controls.

Parameters:
- STEPW, 6, width of the step counter and mpySteps (max 63 steps).

Ports:
- eboxClk  in  1  EBOX clock; all state changes on rising edge.
- eboxResetN  in  1  synchronous active-low reset.
- mpyStart  in  1  start request, sampled only in IDLE.
- mpyDivide  in  1  0 = multiply, 1 = divide; latched with start.
- mpySteps  in  STEPW  step count; latched with start.
- mpyAbort  in  1  abort (page fail/interrupt); returns to IDLE.
- AD_00  in  1  AD sign; forms the divide quotient bit.
- CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload  out  1 each  AR load strobes.
- CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr  out  1 each  AR clears.
- CTL_ARL_SEL, CTL_ARR_SEL  out  3  AR mux select.
- CTL_ARXL_SEL, CTL_ARXR_SEL  out  3  ARX mux select.
- CTL_ARX_LOAD  out  1  ARX load.
- CTL_MQ_SEL  out  2  MQ select.
- CTL_MQM_SEL  out  2  MQM select.
- CTL_MQM_EN  out  1  MQM enable.
- mpyBusy  out  1  high SETUP through DONE.
- mpyDone  out  1  one-cycle completion pulse.
- mpyCount  out  STEPW  remaining steps.
- mpyQbit  out  1  last quotient bit, ~AD_00 registered.

Behaviour:
- Reset (eboxResetN=0 at an edge), from any state including mid-operation:
  - state IDLE.
  - All outputs 0, including mpyCount and mpyQbit.
- Select encodings:
  - AR sel: 0 = hold, 1 = AD, 2 = AD*2, 3 = AD*.5.
  - ARX sel: 0 = zero, 1 = ADX, 2 = ARX*2, 3 = ARX*.5.
  - MQ sel: 0 = hold, 1 = shift right, 2 = load from AR, 3 = shift left with mpyQbit in.
  - MQM sel: 0 = MQ, 1 = MQ*2, 2 = MQ*.25.
- Outputs are Moore, decoded from the state register; they change only at clock edges. Any field not listed for a state is 0.
- States and outputs:
  - IDLE:
    - All datapath outputs 0.
    - mpyStart=1 latches mpyDivide and mpySteps into count. Next state: SETUP.
  - SETUP (1 cycle):
    - All three AR clears = 1.
    - CTL_ARX_LOAD=1 with ARXL/ARXR sel = 0, which clears ARX.
    - MQ_SEL=2.
    - Next: LOOP if count != 0, else FIX.
  - LOOP (one cycle per step):
    - All three AR loads = 1. CTL_ARX_LOAD=1. MQM_EN=1.
    - Multiply: AR sel = 3, ARX sel = 3, MQ_SEL=1, MQM_SEL=2.
    - Divide: AR sel = 2, ARX sel = 2, MQ_SEL=3, MQM_SEL=1, mpyQbit <= ~AD_00 each LOOP cycle.
    - count decrements (6-bit, no wrap: never decrements from 0).
    - Next: FIX when count == 1, else stay in LOOP.
  - FIX (1 cycle):
    - All three AR loads = 1, AR sel = 1.
    - No ARX or MQ activity.
    - Next: DONE.
  - DONE (1 cycle):
    - mpyDone=1, datapath outputs 0.
    - Next: IDLE.
- mpyBusy=1 in SETUP, LOOP, FIX and DONE.
- Latency: start sampled at edge k gives:
  - SETUP during cycle k+1.
  - LOOP during k+2 .. k+1+N.
  - FIX during k+2+N.
  - DONE during k+3+N.
  - IDLE at k+4+N.
  - N=0 skips LOOP.
- mpyAbort:
  - In any non-IDLE state it forces IDLE at the next edge. No DONE pulse; count is cleared.
  - Abort has priority over all transitions.
  - Abort in IDLE is ignored. Abort with start in IDLE: start wins.
- mpyStart while busy is ignored; there is no queuing.
- Start in the same cycle as DONE is ignored, because the FSM is not in IDLE then.
- Reset has priority over abort and start.

Test Plan:
- Reset: hold eboxResetN=0 for 2 cycles with mpyStart=1 -> all outputs 0, mpyBusy=0, stays IDLE after release until the next start.
- Multiply N=4: start at edge 0 -> SETUP cycle 1 (clears=1, MQ_SEL=2), LOOP cycles 2-5 (AR sel 3, MQ_SEL=1, mpyCount 4,3,2,1), FIX cycle 6 (AR sel 1), mpyDone=1 cycle 7 only, mpyBusy low at cycle 8.
- Divide N=3, AD_00 = 0,1,0 during LOOP -> AR sel 2, MQ_SEL=3, mpyQbit sequence 1,0,1; mpyDone in cycle 6.
- N=0: start -> SETUP, FIX, DONE in consecutive cycles; no LOOP strobes.
- Abort during the 2nd LOOP cycle with N=5 -> IDLE next cycle, all strobes 0, mpyCount=0, no mpyDone. A new start then runs a full sequence.
- Start pulsed during LOOP and during DONE -> ignored; single mpyDone; IDLE after DONE.
